// File: rtl/axi_decerr_responder.sv
// Default AXI4 slave: drains unmapped bursts and answers DECERR on B and R.
// Keeps a saturating error count and the most recent faulting address.
module axi_decerr_responder #(
    parameter int unsigned          IdWidth   = 5,
    parameter int unsigned          AddrWidth = 64,
    parameter int unsigned          DataWidth = 64,
    parameter logic [DataWidth-1:0] ErrData   = 64'hDEAD_BEEF_DEAD_BEEF
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 aw_valid_i,
    output logic                 aw_ready_o,
    input  logic [IdWidth-1:0]   aw_id_i,
    input  logic [AddrWidth-1:0] aw_addr_i,
    input  logic [7:0]           aw_len_i,
    input  logic                 w_valid_i,
    output logic                 w_ready_o,
    input  logic                 w_last_i,
    output logic                 b_valid_o,
    input  logic                 b_ready_i,
    output logic [IdWidth-1:0]   b_id_o,
    output logic [1:0]           b_resp_o,
    input  logic                 ar_valid_i,
    output logic                 ar_ready_o,
    input  logic [IdWidth-1:0]   ar_id_i,
    input  logic [AddrWidth-1:0] ar_addr_i,
    input  logic [7:0]           ar_len_i,
    output logic                 r_valid_o,
    input  logic                 r_ready_i,
    output logic [IdWidth-1:0]   r_id_o,
    output logic [DataWidth-1:0] r_data_o,
    output logic [1:0]           r_resp_o,
    output logic                 r_last_o,
    output logic [15:0]          err_cnt_o,
    output logic [AddrWidth-1:0] last_err_addr_o,
    output logic                 last_err_write_o
);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

    w_state_e             w_state_q, w_state_d;
    r_state_e             r_state_q, r_state_d;
    logic                 live_q;
    logic [IdWidth-1:0]   b_id_q, b_id_d;
    logic [IdWidth-1:0]   r_id_q, r_id_d;
    logic [7:0]           r_len_q, r_len_d;
    logic [7:0]           r_beat_q, r_beat_d;
    logic [15:0]          err_cnt_q, err_cnt_d;
    logic [AddrWidth-1:0] last_addr_q, last_addr_d;
    logic                 last_wr_q, last_wr_d;
    logic                 aw_hs, ar_hs;
    logic [16:0]          cnt_sum;
    logic                 unused_aw_len;

    // Burst end is signalled by w_last only.
    assign unused_aw_len = ^aw_len_i;

    assign aw_hs = aw_valid_i & aw_ready_o;
    assign ar_hs = ar_valid_i & ar_ready_o;

    always_comb begin
        w_state_d  = w_state_q;
        b_id_d     = b_id_q;
        aw_ready_o = 1'b0;
        w_ready_o  = 1'b0;
        b_valid_o  = 1'b0;
        unique case (w_state_q)
            W_IDLE: begin
                aw_ready_o = live_q;
                if (aw_valid_i && live_q) begin
                    b_id_d    = aw_id_i;
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                w_ready_o = 1'b1;
                if (w_valid_i && w_last_i) begin
                    w_state_d = W_RESP;
                end
            end
            W_RESP: begin
                b_valid_o = 1'b1;
                if (b_ready_i) begin
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        r_state_d  = r_state_q;
        r_id_d     = r_id_q;
        r_len_d    = r_len_q;
        r_beat_d   = r_beat_q;
        ar_ready_o = 1'b0;
        r_valid_o  = 1'b0;
        unique case (r_state_q)
            R_IDLE: begin
                ar_ready_o = live_q;
                if (ar_valid_i && live_q) begin
                    r_id_d    = ar_id_i;
                    r_len_d   = ar_len_i;
                    r_beat_d  = 8'd0;
                    r_state_d = R_DATA;
                end
            end
            R_DATA: begin
                r_valid_o = 1'b1;
                if (r_ready_i) begin
                    r_beat_d = r_beat_q + 8'd1;
                    if (r_beat_q == r_len_q) begin
                        r_state_d = R_IDLE;
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // 17-bit sum so a +2 near the top saturates instead of wrapping.
    assign cnt_sum   = {1'b0, err_cnt_q} + 17'(aw_hs) + 17'(ar_hs);
    assign err_cnt_d = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];

    always_comb begin
        last_addr_d = last_addr_q;
        last_wr_d   = last_wr_q;
        if (aw_hs) begin
            last_addr_d = aw_addr_i;
            last_wr_d   = 1'b1;
        end else if (ar_hs) begin
            last_addr_d = ar_addr_i;
            last_wr_d   = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            w_state_q   <= W_IDLE;
            r_state_q   <= R_IDLE;
            live_q      <= 1'b0;
            b_id_q      <= '0;
            r_id_q      <= '0;
            r_len_q     <= '0;
            r_beat_q    <= '0;
            err_cnt_q   <= '0;
            last_addr_q <= '0;
            last_wr_q   <= 1'b0;
        end else begin
            w_state_q   <= w_state_d;
            r_state_q   <= r_state_d;
            live_q      <= 1'b1;
            b_id_q      <= b_id_d;
            r_id_q      <= r_id_d;
            r_len_q     <= r_len_d;
            r_beat_q    <= r_beat_d;
            err_cnt_q   <= err_cnt_d;
            last_addr_q <= last_addr_d;
            last_wr_q   <= last_wr_d;
        end
    end

    assign b_id_o           = b_id_q;
    assign b_resp_o         = 2'b11;
    assign r_id_o           = r_id_q;
    assign r_data_o         = ErrData;
    assign r_resp_o         = 2'b11;
    assign r_last_o         = (r_state_q == R_DATA) && (r_beat_q == r_len_q);
    assign err_cnt_o        = err_cnt_q;
    assign last_err_addr_o  = last_addr_q;
    assign last_err_write_o = last_wr_q;

endmodule

// File: tb/tb_axi_decerr_responder.sv
// Bench for axi_decerr_responder: directed and random bursts vs a
// transaction-level model of counts, last address and beat sequences.
module tb_axi_decerr_responder;

    localparam logic [63:0] ERR = 64'hDEAD_BEEF_DEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        aw_valid = 1'b0, aw_ready;
    logic [4:0]  aw_id = '0;
    logic [63:0] aw_addr = '0;
    logic [7:0]  aw_len = '0;
    logic        w_valid = 1'b0, w_ready, w_last = 1'b0;
    logic        b_valid, b_ready = 1'b0;
    logic [4:0]  b_id;
    logic [1:0]  b_resp;
    logic        ar_valid = 1'b0, ar_ready;
    logic [4:0]  ar_id = '0;
    logic [63:0] ar_addr = '0;
    logic [7:0]  ar_len = '0;
    logic        r_valid, r_ready = 1'b0;
    logic [4:0]  r_id;
    logic [63:0] r_data;
    logic [1:0]  r_resp;
    logic        r_last;
    logic [15:0] err_cnt;
    logic [63:0] last_addr;
    logic        last_wr;

    always #5 clk = ~clk;

    axi_decerr_responder dut (
        .clk_i(clk), .rst_ni(rst_n),
        .aw_valid_i(aw_valid), .aw_ready_o(aw_ready),
        .aw_id_i(aw_id), .aw_addr_i(aw_addr), .aw_len_i(aw_len),
        .w_valid_i(w_valid), .w_ready_o(w_ready), .w_last_i(w_last),
        .b_valid_o(b_valid), .b_ready_i(b_ready),
        .b_id_o(b_id), .b_resp_o(b_resp),
        .ar_valid_i(ar_valid), .ar_ready_o(ar_ready),
        .ar_id_i(ar_id), .ar_addr_i(ar_addr), .ar_len_i(ar_len),
        .r_valid_o(r_valid), .r_ready_i(r_ready),
        .r_id_o(r_id), .r_data_o(r_data), .r_resp_o(r_resp),
        .r_last_o(r_last),
        .err_cnt_o(err_cnt), .last_err_addr_o(last_addr),
        .last_err_write_o(last_wr)
    );

    int          checks = 0;
    int          errors = 0;
    int          cnt_m = 0;
    logic [63:0] last_addr_m = '0;
    logic        last_wr_m = 1'b0;
    logic [4:0]  exp_bid = '0;
    logic [4:0]  exp_rid = '0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    function automatic void note(input bit aw, input bit ar,
                                 input logic [63:0] a_aw,
                                 input logic [63:0] a_ar);
        cnt_m = cnt_m + int'(aw) + int'(ar);
        if (cnt_m > 65535) cnt_m = 65535;
        if (aw) begin
            last_addr_m = a_aw;
            last_wr_m   = 1'b1;
        end else if (ar) begin
            last_addr_m = a_ar;
            last_wr_m   = 1'b0;
        end
    endfunction

    task automatic chk_err();
        chk("err_cnt", 64'(err_cnt), 64'(cnt_m));
        chk("last_addr", last_addr, last_addr_m);
        chk("last_wr", 64'(last_wr), 64'(last_wr_m));
    endtask

    task automatic accept(input bit wr, input bit rd,
                          input logic [4:0] idw, input logic [63:0] aa,
                          input logic [4:0] idr, input logic [63:0] ra,
                          input int len);
        int g = 0;
        while (((wr && !aw_ready) || (rd && !ar_ready)) && g < 50) begin
            @(negedge clk);
            g++;
        end
        chk("ready_wait", 64'(g < 50), 64'd1);
        aw_valid = wr; aw_id = idw; aw_addr = aa; aw_len = 8'($urandom);
        ar_valid = rd; ar_id = idr; ar_addr = ra; ar_len = 8'(len);
        @(negedge clk);
        aw_valid = 1'b0;
        ar_valid = 1'b0;
        note(wr, rd, aa, ra);
        chk_err();
        if (wr) begin
            exp_bid = idw;
            chk("w_ready_after_aw", 64'(w_ready), 64'd1);
            chk("aw_ready_busy", 64'(aw_ready), 64'd0);
        end
        if (rd) begin
            exp_rid = idr;
            chk("r_valid_after_ar", 64'(r_valid), 64'd1);
            chk("ar_ready_busy", 64'(ar_ready), 64'd0);
        end
    endtask

    task automatic write_data(input int nbeats, input int bstall,
                              input int maxgap);
        for (int i = 0; i < nbeats; i++) begin
            int gap = $urandom_range(0, maxgap);
            for (int g = 0; g < gap; g++) begin
                w_valid = 1'b0;
                w_last  = 1'($urandom);
                @(negedge clk);
                chk("w_ready_hold", 64'(w_ready), 64'd1);
                chk("b_early", 64'(b_valid), 64'd0);
            end
            w_valid = 1'b1;
            w_last  = (i == nbeats - 1);
            @(negedge clk);
            if (i < nbeats - 1) begin
                chk("b_early", 64'(b_valid), 64'd0);
                chk("w_ready_mid", 64'(w_ready), 64'd1);
            end
        end
        w_valid = 1'b0;
        w_last  = 1'b0;
        chk("b_valid", 64'(b_valid), 64'd1);
        chk("b_id", 64'(b_id), 64'(exp_bid));
        chk("b_resp", 64'(b_resp), 64'd3);
        chk("w_ready_resp", 64'(w_ready), 64'd0);
        for (int s = 0; s < bstall; s++) begin
            @(negedge clk);
            chk("b_valid_stall", 64'(b_valid), 64'd1);
            chk("aw_ready_stall", 64'(aw_ready), 64'd0);
            chk("b_id_stall", 64'(b_id), 64'(exp_bid));
        end
        b_ready = 1'b1;
        @(negedge clk);
        b_ready = 1'b0;
        chk("aw_ready_after_b", 64'(aw_ready), 64'd1);
        chk("b_valid_drop", 64'(b_valid), 64'd0);
    endtask

    // mode 0: ready high, 1: toggle starting low, 2: random
    task automatic read_data(input int len, input int mode);
        int beat = 0;
        int cyc = 0;
        while (beat <= len && cyc < 3000) begin
            chk("r_valid", 64'(r_valid), 64'd1);
            chk("r_last", 64'(r_last), 64'(beat == len));
            chk("r_id", 64'(r_id), 64'(exp_rid));
            chk("r_data", r_data, ERR);
            chk("r_resp", 64'(r_resp), 64'd3);
            chk("ar_ready_rd", 64'(ar_ready), 64'd0);
            case (mode)
                0:       r_ready = 1'b1;
                1:       r_ready = cyc[0];
                default: r_ready = 1'($urandom);
            endcase
            @(negedge clk);
            if (r_ready) beat++;
            cyc++;
        end
        r_ready = 1'b0;
        chk("r_beats", 64'(beat), 64'(len + 1));
        chk("r_valid_end", 64'(r_valid), 64'd0);
        chk("ar_ready_end", 64'(ar_ready), 64'd1);
        if (mode == 0) chk("r_cycles", 64'(cyc), 64'(len + 1));
    endtask

    initial begin
        logic [63:0] a;
        logic [63:0] b;
        int          g;
        int          len;

        @(negedge clk);
        @(negedge clk);
        chk("rst_aw_ready", 64'(aw_ready), 64'd0);
        chk("rst_ar_ready", 64'(ar_ready), 64'd0);
        chk("rst_w_ready", 64'(w_ready), 64'd0);
        chk("rst_b_valid", 64'(b_valid), 64'd0);
        chk("rst_r_valid", 64'(r_valid), 64'd0);
        chk("rst_b_resp", 64'(b_resp), 64'd3);
        chk("rst_r_resp", 64'(r_resp), 64'd3);
        chk("rst_b_id", 64'(b_id), 64'd0);
        chk("rst_r_id", 64'(r_id), 64'd0);
        chk("rst_r_last", 64'(r_last), 64'd0);
        chk_err();
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_aw_ready", 64'(aw_ready), 64'd1);
        chk("rel_ar_ready", 64'(ar_ready), 64'd1);

        w_valid = 1'b1;
        w_last  = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("w_before_aw", 64'(w_ready), 64'd0);
            chk("b_before_aw", 64'(b_valid), 64'd0);
        end
        w_valid = 1'b0;
        w_last  = 1'b0;

        accept(1, 0, 5'h13, 64'h5000_0000, 0, 0, 0);
        write_data(1, 0, 0);

        accept(0, 1, 0, 0, 5'h02, 64'h6000_1000, 3);
        read_data(3, 0);

        accept(0, 1, 0, 0, 5'h07, 64'h7000_0040, 1);
        read_data(1, 1);
        accept(1, 0, 5'h0A, 64'h7100_0000, 0, 0, 0);
        write_data(1, 5, 0);

        a = 64'hA000_0000_0000_1234;
        b = 64'hB000_0000_0000_5678;
        accept(1, 1, 5'h11, a, 5'h04, b, 2);
        write_data(2, 1, 1);
        chk("r_wait_valid", 64'(r_valid), 64'd1);
        chk("r_wait_last", 64'(r_last), 64'd0);
        read_data(2, 2);

        for (int it = 0; it < 16; it++) begin
            int kind = $urandom_range(0, 2);
            a   = {$urandom, $urandom};
            b   = {$urandom, $urandom};
            len = (it == 5) ? 255 : $urandom_range(0, 6);
            accept(kind != 1, kind != 0, 5'($urandom), a,
                   5'($urandom), b, len);
            if (kind != 1) write_data($urandom_range(1, 4),
                                      $urandom_range(0, 3), 2);
            if (kind != 0) read_data(len, 2);
        end

        accept(0, 1, 0, 0, 5'h09, 64'h8000_0000, 7);
        r_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("mid_r_valid", 64'(r_valid), 64'd1);
            chk("mid_r_last", 64'(r_last), 64'd0);
        end
        rst_n   = 1'b0;
        r_ready = 1'b0;
        @(negedge clk);
        cnt_m = 0; last_addr_m = '0; last_wr_m = 1'b0;
        exp_rid = '0;
        chk("mrst_r_valid", 64'(r_valid), 64'd0);
        chk("mrst_ar_ready", 64'(ar_ready), 64'd0);
        chk("mrst_r_id", 64'(r_id), 64'd0);
        chk_err();
        rst_n = 1'b1;
        @(negedge clk);
        chk("mrel_ar_ready", 64'(ar_ready), 64'd1);
        accept(0, 1, 0, 0, 5'h1F, 64'h9000_0000, 0);
        read_data(0, 0);

        w_valid = 1'b1; w_last = 1'b1; b_ready = 1'b1; r_ready = 1'b1;
        ar_len = 8'd0;
        g = 0;
        while (cnt_m < 65534 && g < 90000) begin
            int rem = 65534 - cnt_m;
            chk("bulk_cnt", 64'(err_cnt), 64'(cnt_m));
            aw_valid = aw_ready && rem >= 1;
            ar_valid = ar_ready && rem >= (aw_valid ? 2 : 1);
            aw_addr  = {$urandom, $urandom};
            ar_addr  = {$urandom, $urandom};
            note(aw_valid, ar_valid, aw_addr, ar_addr);
            @(negedge clk);
            g++;
        end
        aw_valid = 1'b0;
        ar_valid = 1'b0;
        chk("bulk_timeout", 64'(g < 90000), 64'd1);
        g = 0;
        while (!(aw_ready && ar_ready) && g < 20) begin
            @(negedge clk);
            g++;
        end
        chk("bulk_drain", 64'(g < 20), 64'd1);
        w_valid = 1'b0; w_last = 1'b0; b_ready = 1'b0; r_ready = 1'b0;
        chk_err();
        chk("pre_sat", 64'(err_cnt), 64'hFFFE);

        a = 64'h1111_2222_3333_4444;
        b = 64'h5555_6666_7777_8888;
        accept(1, 1, 5'h03, a, 5'h05, b, 0);
        chk("sat_both", 64'(err_cnt), 64'hFFFF);
        write_data(1, 0, 0);
        read_data(0, 0);
        accept(0, 1, 0, 0, 5'h06, 64'hCAFE_0000, 0);
        chk("sat_hold", 64'(err_cnt), 64'hFFFF);
        read_data(0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_decerr_responder.md
# axi_decerr_responder

Default AXI4 slave on the SoC crossbar for address space not claimed by DRAM, ZYNQ, PLIC, CLINT, ROM or Debug. It accepts any burst, drains write data and returns DECERR on B and R with the full burst length, so masters never hang on unmapped accesses. It also keeps a saturating error counter and the last faulting address for debug visibility. Read and write channels are independent; each allows one outstanding transaction.

## Interface
- IdWidth, 5: ID width on the slave side (master ID 4 plus crossbar index bit).
- AddrWidth, 64: address width.
- DataWidth, 64: R data width.
- ErrData, 64'hDEAD_BEEF_DEAD_BEEF: constant driven on r_data_o during error beats.
- clk_i  in  1  clock; all logic on the rising edge.
- rst_ni  in  1  reset, synchronous, active-low.
- aw_valid_i / aw_ready_o  in/out  1  AW handshake.
- aw_id_i  in  IdWidth; aw_addr_i  in  AddrWidth; aw_len_i  in  8.
- w_valid_i / w_ready_o  in/out  1  W handshake; w_last_i  in  1 (w_data/w_strb ignored, not ported).
- b_valid_o / b_ready_i  out/in  1  B handshake; b_id_o  out  IdWidth; b_resp_o  out  2.
- ar_valid_i / ar_ready_o  in/out  1  AR handshake; ar_id_i  in  IdWidth; ar_addr_i  in  AddrWidth; ar_len_i  in  8.
- r_valid_o / r_ready_i  out/in  1  R handshake; r_id_o  out  IdWidth; r_data_o  out  DataWidth; r_resp_o  out  2; r_last_o  out  1.
- err_cnt_o  out  16  saturating count of accepted AW+AR requests.
- last_err_addr_o  out  AddrWidth  address of most recent accepted request.
- last_err_write_o  out  1  1 if that request was a write.

## Operation
- Write FSM W_IDLE -> W_DATA -> W_RESP -> W_IDLE.
  - W_IDLE: aw_ready_o=1. On AW handshake: latch aw_id_i, go to W_DATA.
  - W_DATA: w_ready_o=1. Each W handshake is consumed. A handshake with w_last_i=1 goes to W_RESP. aw_len_i is not used to terminate the burst.
  - W_RESP: b_valid_o=1, b_id_o=latched ID, b_resp_o=2'b11 (DECERR). On b_ready_i go to W_IDLE.
- Read FSM R_IDLE -> R_DATA -> R_IDLE.
  - R_IDLE: ar_ready_o=1. On AR handshake: latch ar_id_i and ar_len_i, clear beat counter, go to R_DATA.
  - R_DATA: r_valid_o=1, r_id_o=latched ID, r_data_o=ErrData, r_resp_o=2'b11.
  - r_last_o=1 exactly when beat counter == latched len. The counter is 8 bit; len=255 yields 256 beats with no wrap before last.
  - Each R handshake increments the counter. A handshake with r_last_o=1 returns to R_IDLE.
- Outputs are constant and stable while valid is high and ready is low.
- Error counter:
  - +1 per AW or AR handshake; +2 if both occur in the same cycle.
  - Saturates at 16'hFFFF. A +2 from 16'hFFFE gives 16'hFFFF.
- Last error:
  - Updates on AW or AR handshake.
  - If both occur in the same cycle, the write wins: aw_addr_i is captured and last_err_write_o=1.
- Reset (rst_ni=0 at a clock edge), including mid-burst:
  - Both FSMs go to IDLE and the counters clear; partial bursts are abandoned.
  - All valid outputs and w_ready_o = 0; aw_ready_o = ar_ready_o = 0 during reset, 1 from the first cycle after release.
  - b_resp_o, r_resp_o = 2'b11 constant; ids, r_last_o, err_cnt_o, last_err_addr_o, last_err_write_o = 0.

## Timing
- All outputs are registered state or decode of state. There is no combinational path from any *_valid_i / *_ready_i to any output.
- AW accepted at cycle N: w_ready_o=1 from N+1.
- Last W beat at cycle M: b_valid_o=1 at M+1.
- B handshake at cycle K: aw_ready_o=1 at K+1. Minimum single-beat write is 3 cycles AW-to-B, one B handshake per 3 cycles.
- AR accepted at cycle N: first r_valid_o at N+1. With r_ready_i held high, beats are back-to-back, last at N+1+len, ar_ready_o=1 at N+2+len.
- err_cnt_o and last_err_* update the cycle after the handshake.
- W beats arriving before the AW handshake are not accepted; w_ready_o stays 0.

## Test plan
- Single write: AW id=5'h13 addr=0x5000_0000 len=0, W last at N+1, b_ready=1 -> b_valid at N+2, b_id=0x13, b_resp=2'b11; err_cnt=1, last_err_addr=0x5000_0000, last_err_write=1.
- 4-beat read: AR id=2 len=3, r_ready=1 -> 4 beats with r_data=ErrData and r_resp=2'b11, r_last only on beat 4; ar_ready high again on the next cycle.
- Backpressure: read len=1 with r_ready toggling 0/1 each cycle -> outputs stable while stalled, exactly 2 beats. B held with b_ready=0 for 5 cycles -> b_valid stays high and aw_ready stays 0.
- Concurrent: AW addr=A and AR addr=B in the same cycle -> err_cnt +2, last_err_addr=A, last_err_write=1, both channels complete independently.
- Saturation: preload 65534 requests, then simultaneous AW+AR -> err_cnt=16'hFFFF; one further request -> still 16'hFFFF.
- Reset mid-burst: AR len=7, assert rst_ni=0 after beat 3 -> next cycle r_valid=0 and err_cnt=0; after release ar_ready=1, and a new AR len=0 returns one beat with r_last=1.
